// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiplier and restoring divider, one iteration per clock.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;     // mul: upper product / div: remainder
   logic [WIDTH-1:0]   work_q, work_d;   // mul: multiplier / div: quotient
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // mul: multiplicand / div: divisor
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_mul_op_s, is_div_op_s, is_sgn_op_s, is_mt_op_s;
   logic               accept_s;
   logic               a_neg_s, b_neg_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_diff_s;
   logic               div_ge_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_neg_s;

   assign is_mul_op_s = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div_op_s = (op == OP_DIV)  || (op == OP_DIVU);
   assign is_sgn_op_s = (op == OP_MULT) || (op == OP_DIV);
   assign is_mt_op_s  = (op == OP_MTHI) || (op == OP_MTLO);

   // Flush wins over a same-cycle request; reserved opcodes are never taken.
   assign accept_s = in_valid && (state_q == ST_IDLE) && !flush &&
                     (is_mul_op_s || is_div_op_s || is_mt_op_s);

   assign a_neg_s = is_sgn_op_s && a[WIDTH-1];
   assign b_neg_s = is_sgn_op_s && b[WIDTH-1];
   assign a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
   assign b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;

   assign mul_sum_s   = {1'b0, acc_q} + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign div_shift_s = {acc_q, work_q[WIDTH-1]};
   assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
   assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});

   assign prod_s     = {acc_q, work_q};
   assign prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && is_mt_op_s) begin
               state_d = ST_DONE;
            end else if (accept_s) begin
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_SIGN;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_SIGN: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state register.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         ST_CALC: busy = 1'b1;
         ST_SIGN: busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: begin
            in_ready = 1'b0;
            busy     = 1'b1;
         end
      endcase
   end

   // Datapath next values: operand capture, iteration step and result commit.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      work_d    = work_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               cnt_d     = {CNT_W{1'b0}};
               acc_d     = {WIDTH{1'b0}};
               div0_d    = 1'b0;
               dz_d      = 1'b0;
               neg_res_d = 1'b0;
               neg_rem_d = 1'b0;
               is_div_d  = is_div_op_s;
               if (is_mul_op_s) begin
                  work_d    = b_mag_s;
                  opnd_d    = a_mag_s;
                  neg_res_d = a_neg_s ^ b_neg_s;
               end else if (is_div_op_s && (b == {WIDTH{1'b0}})) begin
                  // Raw dividend is parked for HI; no iteration, no sign fix-up.
                  work_d = a;
                  opnd_d = b;
                  dz_d   = 1'b1;
                  div0_d = 1'b1;
               end else if (is_div_op_s) begin
                  work_d    = a_mag_s;
                  opnd_d    = b_mag_s;
                  neg_res_d = a_neg_s ^ b_neg_s;
                  neg_rem_d = a_neg_s;
               end else if (op == OP_MTHI) begin
                  hi_d = a;
               end else begin
                  lo_d = a;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dz_q) begin
               acc_d = acc_q;
            end else if (is_div_q) begin
               acc_d  = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
               work_d = {work_q[WIDTH-2:0], div_ge_s};
            end else begin
               acc_d  = mul_sum_s[WIDTH:1];
               work_d = {mul_sum_s[0], work_q[WIDTH-1:1]};
            end
         end
         ST_SIGN: begin
            if (flush) begin
               hi_d = hi_q;
            end else if (dz_q) begin
               hi_d = work_q;
               lo_d = {WIDTH{1'b1}};
            end else if (is_div_q) begin
               lo_d = neg_res_q ? ({WIDTH{1'b0}} - work_q) : work_q;
               hi_d = neg_rem_q ? ({WIDTH{1'b0}} - acc_q) : acc_q;
            end else if (neg_res_q) begin
               hi_d = prod_neg_s[2*WIDTH-1:WIDTH];
               lo_d = prod_neg_s[WIDTH-1:0];
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
         end
         ST_DONE: cnt_d = cnt_q;
         default: cnt_d = cnt_q;
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= {CNT_W{1'b0}};
         acc_q     <= {WIDTH{1'b0}};
         work_q    <= {WIDTH{1'b0}};
         opnd_q    <= {WIDTH{1'b0}};
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         work_q    <= work_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign div0 = div0_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with hand-computed HI/LO results.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         flush;
   logic         busy;
   logic         done;
   logic         div0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .div0     (div0),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits for in_ready, presents one request for exactly the accept edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int g;
      g = 0;
      while (!in_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 100) check("ready_timeout", 64'd0, 64'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts clock edges after the accept edge until done is seen.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int n;
      int cnt;
      rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_ready", 64'(in_ready), 64'h1);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_div0", 64'(div0), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // MULT -3 * 5
      issue(3'd0, 32'hFFFFFFFD, 32'h00000005);
      check("mult_busy", 64'(busy), 64'h1);
      wait_done(n);
      check("mult_latency", 64'(n), 64'd33);
      check("mult_hi", 64'(hi), 64'hFFFFFFFF);
      check("mult_lo", 64'(lo), 64'hFFFFFFF1);

      // MULTU max*max, with a second request held behind it
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      op = 3'd5; a = 32'hAAAA5555; in_valid = 1'b1;
      cnt = 0; n = 0;
      while (!done && n < 100) begin
         if (!busy || in_ready) cnt++;
         @(posedge clk); #1;
         n++;
      end
      check("multu_busy_low", 64'(cnt), 64'd0);
      check("multu_latency", 64'(n), 64'd33);
      check("multu_hi", 64'(hi), 64'hFFFFFFFE);
      check("multu_lo", 64'(lo), 64'h00000001);
      check("held_done_ready", 64'(in_ready), 64'h0);
      @(posedge clk); #1;
      check("held_idle_ready", 64'(in_ready), 64'h1);
      check("held_not_taken", 64'(lo), 64'h00000001);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("held_taken_lo", 64'(lo), 64'hAAAA5555);
      check("held_taken_done", 64'(done), 64'h1);

      // Signed and unsigned divides
      issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
      wait_done(n);
      check("div_latency", 64'(n), 64'd33);
      check("div_lo", 64'(lo), 64'hFFFFFFFD);
      check("div_hi", 64'(hi), 64'hFFFFFFFF);
      check("div_div0", 64'(div0), 64'h0);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_done(n);
      check("divmin_lo", 64'(lo), 64'h80000000);
      check("divmin_hi", 64'(hi), 64'h0);
      check("divmin_div0", 64'(div0), 64'h0);
      issue(3'd2, 32'h00000007, 32'hFFFFFFFE);
      wait_done(n);
      check("divneg_lo", 64'(lo), 64'hFFFFFFFD);
      check("divneg_hi", 64'(hi), 64'h00000001);
      issue(3'd3, 32'hFFFFFFFF, 32'h00000010);
      wait_done(n);
      check("divu_lo", 64'(lo), 64'h0FFFFFFF);
      check("divu_hi", 64'(hi), 64'h0000000F);

      // Divide by zero, then a MULTU clears the flag
      issue(3'd3, 32'h00000007, 32'h00000000);
      wait_done(n);
      check("dz_latency", 64'(n), 64'd33);
      check("dz_div0", 64'(div0), 64'h1);
      check("dz_hi", 64'(hi), 64'h00000007);
      check("dz_lo", 64'(lo), 64'hFFFFFFFF);
      issue(3'd1, 32'h00000003, 32'h00000004);
      check("dz_clear", 64'(div0), 64'h0);
      wait_done(n);
      check("small_hi", 64'(hi), 64'h0);
      check("small_lo", 64'(lo), 64'h0000000C);

      // MTHI: written on the accept edge, done right after
      issue(3'd4, 32'h12345678, 32'h0);
      check("mthi_hi", 64'(hi), 64'h12345678);
      wait_done(n);
      check("mthi_latency", 64'(n), 64'd0);

      // Flush at CALC cycle 10 of a MULT
      issue(3'd0, 32'h00000002, 32'h00000003);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", 64'(in_ready), 64'h1);
      check("flush_busy", 64'(busy), 64'h0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) cnt++;
         @(posedge clk); #1;
      end
      check("flush_no_done", 64'(cnt), 64'd0);
      check("flush_hi", 64'(hi), 64'h12345678);
      check("flush_lo", 64'(lo), 64'h0000000C);

      // Request in the same cycle as flush is ignored
      op = 3'd5; a = 32'hDEADBEEF; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_acc_done", 64'(done), 64'h0);
      check("flush_acc_lo", 64'(lo), 64'h0000000C);

      // Reserved opcode is ignored
      op = 3'd6; a = 32'h11111111; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rsv_ready", 64'(in_ready), 64'h1);
      check("rsv_done", 64'(done), 64'h0);
      check("rsv_lo", 64'(lo), 64'h0000000C);

      // MTLO
      issue(3'd5, 32'hCAFEF00D, 32'h0);
      check("mtlo_lo", 64'(lo), 64'hCAFEF00D);
      check("mtlo_hi", 64'(hi), 64'h12345678);

      // Flush while in DONE does not undo the commit
      issue(3'd1, 32'h00000002, 32'h00000003);
      wait_done(n);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_done_hi", 64'(hi), 64'h0);
      check("flush_done_lo", 64'(lo), 64'h00000006);

      // Asynchronous reset mid-DIV
      issue(3'd2, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_ready", 64'(in_ready), 64'h1);
      check("arst_busy", 64'(busy), 64'h0);
      check("arst_hi", 64'(hi), 64'h0);
      check("arst_lo", 64'(lo), 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(3'd3, 32'd100, 32'd7);
      wait_done(n);
      check("post_rst_lo", 64'(lo), 64'd14);
      check("post_rst_hi", 64'(hi), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
